multiplicador_control_fsm: RTL and testbench

- Controller FSM for the MMP sequential shift-add multiplier.
- Drives the one-hot 4-bit control buses of the A (accumulator), Q (multiplier) and P (iteration count) universal registers.
- Samples datapath status flags and reports completion to the top level.
- Outputs are registered on posedge; the datapath registers update on the following negedge, so status flags are stable for every posedge decision.

---
 rtl/multiplicador_control_fsm.sv | 167 ++++++++++++++++
 tb/tb_multiplicador_control_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_control_fsm.sv
// Control FSM for the MMP sequential shift-add multiplier: sequences the A/Q/P
// universal registers and reports completion, with an iteration watchdog.
module multiplicador_control_fsm #(
    parameter int ANCHO = 8,
    parameter int CW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iniciar,
    input  logic       q0,
    input  logic       p_cero,
    output logic [3:0] control_a,
    output logic [3:0] control_q,
    output logic [3:0] control_p,
    output logic       ocupado,
    output logic       listo,
    output logic       valido,
    output logic       error
);

    localparam logic [3:0] COD_MEM   = 4'b0000;
    localparam logic [3:0] COD_SUMA  = 4'b1000;
    localparam logic [3:0] COD_DESPL = 4'b0100;
    localparam logic [3:0] COD_DECR  = 4'b0010;
    localparam logic [3:0] COD_CARGA = 4'b0001;

    localparam logic [CW-1:0] WD_MAX = CW'(ANCHO);

    typedef enum logic [2:0] {
        REPOSO    = 3'd0,
        CARGA     = 3'd1,
        PRUEBA    = 3'd2,
        SUMAR     = 3'd3,
        DESPLAZAR = 3'd4,
        FIN       = 3'd5
    } estado_t;

    estado_t       state_q, state_d;
    logic          iniciar_prev_q;
    logic [CW-1:0] wd_q, wd_d;
    logic [3:0]    ctrl_a_q, ctrl_a_d;
    logic [3:0]    ctrl_q_q, ctrl_q_d;
    logic [3:0]    ctrl_p_q, ctrl_p_d;
    logic          ocupado_q, ocupado_d;
    logic          listo_q, listo_d;
    logic          valido_q, valido_d;
    logic          error_q, error_d;
    logic          start_s;

    // Next state, plus outputs decoded from the state being entered so they register with it
    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        valido_d = valido_q;
        error_d  = error_q;
        ctrl_a_d = COD_MEM;
        ctrl_q_d = COD_MEM;
        ctrl_p_d = COD_MEM;
        ocupado_d = 1'b0;
        listo_d   = 1'b0;
        start_s   = iniciar & ~iniciar_prev_q;

        case (state_q)
            REPOSO: begin
                if (start_s) begin
                    state_d = CARGA;
                end else begin
                    state_d = REPOSO;
                end
            end
            CARGA:     state_d = PRUEBA;
            PRUEBA: begin
                // p_cero outranks the watchdog, so a normal finish never flags error
                if (p_cero) begin
                    state_d = FIN;
                end else if (wd_q == WD_MAX) begin
                    state_d = FIN;
                    error_d = 1'b1;
                end else if (q0) begin
                    state_d = SUMAR;
                end else begin
                    state_d = DESPLAZAR;
                end
            end
            SUMAR:     state_d = DESPLAZAR;
            DESPLAZAR: state_d = PRUEBA;
            FIN:       state_d = REPOSO;
            default:   state_d = REPOSO;
        endcase

        case (state_d)
            REPOSO: begin
                ocupado_d = 1'b0;
            end
            CARGA: begin
                ctrl_a_d  = COD_CARGA;
                ctrl_q_d  = COD_CARGA;
                ctrl_p_d  = COD_CARGA;
                ocupado_d = 1'b1;
                valido_d  = 1'b0;
                error_d   = 1'b0;
                wd_d      = {CW{1'b0}};
            end
            PRUEBA: begin
                ocupado_d = 1'b1;
            end
            SUMAR: begin
                ctrl_a_d  = COD_SUMA;
                ocupado_d = 1'b1;
            end
            DESPLAZAR: begin
                ctrl_a_d  = COD_DESPL;
                ctrl_q_d  = COD_DESPL;
                ctrl_p_d  = COD_DECR;
                ocupado_d = 1'b1;
                if (wd_q < WD_MAX) begin
                    wd_d = wd_q + CW'(1);
                end else begin
                    wd_d = wd_q;
                end
            end
            FIN: begin
                listo_d  = 1'b1;
                valido_d = 1'b1;
            end
            default: begin
                ocupado_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= REPOSO;
            iniciar_prev_q <= 1'b1;
            wd_q           <= {CW{1'b0}};
            ctrl_a_q       <= COD_MEM;
            ctrl_q_q       <= COD_MEM;
            ctrl_p_q       <= COD_MEM;
            ocupado_q      <= 1'b0;
            listo_q        <= 1'b0;
            valido_q       <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            iniciar_prev_q <= iniciar;
            wd_q           <= wd_d;
            ctrl_a_q       <= ctrl_a_d;
            ctrl_q_q       <= ctrl_q_d;
            ctrl_p_q       <= ctrl_p_d;
            ocupado_q      <= ocupado_d;
            listo_q        <= listo_d;
            valido_q       <= valido_d;
            error_q        <= error_d;
        end
    end

    assign control_a = ctrl_a_q;
    assign control_q = ctrl_q_q;
    assign control_p = ctrl_p_q;
    assign ocupado   = ocupado_q;
    assign listo     = listo_q;
    assign valido    = valido_q;
    assign error     = error_q;

endmodule

// File: tb/tb_multiplicador_control_fsm.sv
// Scoreboard bench: a negedge datapath model closes the loop; expected control
// traces are queued per run and popped by a monitor on every busy/listo cycle.
module tb_multiplicador_control_fsm;

    localparam int         ANCHO = 8;
    localparam logic [7:0] MCAND = 8'hC3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iniciar = 1'b1;
    logic       q0, p_cero;
    logic [3:0] control_a, control_q, control_p;
    logic       ocupado, listo, valido, error;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] q;
        logic [3:0] p;
        logic       ocup;
        logic       listo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] a_r = 8'd0, q_r = 8'd0, p_r = 8'd0, mult_r = 8'd0;
    logic       c_r = 1'b0;
    logic       pz_tie = 1'b0;

    multiplicador_control_fsm #(.ANCHO(ANCHO), .CW(4)) dut (
        .clk(clk), .rst(rst), .iniciar(iniciar), .q0(q0), .p_cero(p_cero),
        .control_a(control_a), .control_q(control_q), .control_p(control_p),
        .ocupado(ocupado), .listo(listo), .valido(valido), .error(error)
    );

    always #5 clk = ~clk;

    assign q0     = q_r[0];
    assign p_cero = pz_tie ? 1'b0 : (p_r == 8'd0);

    // Datapath model: registers update on the negedge after the controls change
    always @(negedge clk) begin
        if (control_a == 4'b0001) begin
            a_r <= 8'd0;
            c_r <= 1'b0;
        end else if (control_a == 4'b1000) begin
            {c_r, a_r} <= {1'b0, a_r} + {1'b0, MCAND};
        end else if (control_a == 4'b0100) begin
            a_r <= {c_r, a_r[7:1]};
            c_r <= 1'b0;
        end
        if (control_q == 4'b0001) q_r <= mult_r;
        else if (control_q == 4'b0100) q_r <= {a_r[0], q_r[7:1]};
        if (control_p == 4'b0001) p_r <= 8'(ANCHO);
        else if (control_p == 4'b0010) p_r <= p_r - 8'd1;
    end

    // Monitor: every cycle the DUT is busy or signalling listo must match the next queued entry
    always @(negedge clk) begin
        exp_t got, e;
        if (rst && (ocupado || listo)) begin
            got = {control_a, control_q, control_p, ocupado, listo};
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL trace: unexpected a=%b q=%b p=%b ocup=%b listo=%b with no entry expected",
                         got.a, got.q, got.p, got.ocup, got.listo);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors = errors + 1;
                    $display("FAIL trace @%0t: got a=%b q=%b p=%b ocup=%b listo=%b, expected a=%b q=%b p=%b ocup=%b listo=%b",
                             $time, got.a, got.q, got.p, got.ocup, got.listo,
                             e.a, e.q, e.p, e.ocup, e.listo);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected per-cycle controls: CARGA, per bit PRUEBA [SUMA] DESPL, final PRUEBA, FIN
    task automatic push_trace(input logic [7:0] m, input int limit);
        exp_t t[$];
        t.push_back({4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0});
        for (int i = 0; i < ANCHO; i++) begin
            t.push_back({4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0});
            if (m[i]) t.push_back({4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0});
            t.push_back({4'b0100, 4'b0100, 4'b0010, 1'b1, 1'b0});
        end
        t.push_back({4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0});
        t.push_back({4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1});
        for (int k = 0; k < limit && k < t.size(); k++) exp_q.push_back(t[k]);
    endtask

    task automatic start_edge();
        @(negedge clk);
        iniciar = 1'b0;
        @(negedge clk);
        iniciar = 1'b1;
    endtask

    // One full operation; exp_lat is cycles from CARGA to FIN
    task automatic run(input logic [7:0] m, input logic pz, input int exp_lat, input logic exp_err);
        int   cnt;
        logic done;
        mult_r = m;
        pz_tie = pz;
        push_trace(m, 1000);
        start_edge();
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                chk("carga clears valido", 32'(valido), 32'd0);
                chk("carga clears error", 32'(error), 32'd0);
            end
            if (listo) done = 1'b1;
        end
        if (!done) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL listo timeout: got none in %0d cycles, expected after %0d", cnt, exp_lat);
        end else begin
            chk("latency", 32'(cnt - 1), 32'(exp_lat));
            chk("valido at fin", 32'(valido), 32'd1);
            chk("error at fin", 32'(error), 32'(exp_err));
            chk("product", 32'({a_r, q_r}), 32'(16'(m) * 16'(MCAND)));
        end
        @(negedge clk);
        chk("listo one cycle", 32'(listo), 32'd0);
        chk("valido held", 32'(valido), 32'd1);
        chk("error held", 32'(error), 32'(exp_err));
        chk("idle after fin", 32'(ocupado), 32'd0);
        chk("trace consumed", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cnt;
        rst = 1'b0;
        iniciar = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset control_a", 32'(control_a), 32'd0);
        chk("reset control_q", 32'(control_q), 32'd0);
        chk("reset control_p", 32'(control_p), 32'd0);
        chk("reset flags", 32'({ocupado, listo, valido, error}), 32'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("held iniciar no start", 32'({ocupado, control_a, control_q, control_p}), 32'd0);
        chk("held iniciar valido", 32'(valido), 32'd0);

        run(8'h00, 1'b0, 18, 1'b0);
        run(8'hFF, 1'b0, 26, 1'b0);
        run(8'hA5, 1'b0, 22, 1'b0);
        run(8'h00, 1'b1, 18, 1'b1);
        run(8'h5A, 1'b0, 22, 1'b0);

        // Reset in the SUMAR cycle of iteration 3, with a start pulse ignored while busy
        mult_r = 8'hFF;
        pz_tie = 1'b0;
        push_trace(8'hFF, 12);
        start_edge();
        cnt = 0;
        while (cnt < 12) begin
            @(negedge clk);
            cnt++;
            if (cnt == 4) iniciar = 1'b0;
            if (cnt == 6) iniciar = 1'b1;
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrun reset codes", 32'({control_a, control_q, control_p}), 32'd0);
        chk("midrun reset ocupado", 32'(ocupado), 32'd0);
        chk("midrun reset valido", 32'(valido), 32'd0);
        chk("midrun reset listo", 32'(listo), 32'd0);
        chk("midrun trace consumed", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("no start after reset", 32'(ocupado), 32'd0);

        run(8'h81, 1'b0, 20, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
